sobel_line_scanner: RTL and testbench
=====================================

SOBEL_LINE_SCANNER -- requirements
Module: sobel_line_scanner

Interface
REQ-001 Parameter: WIDTH, default 240, pixels per line (2..256).
REQ-002 Clock  in  1  sole clock; all state updates on rising edge.
REQ-003 Reset  in  1  asynchronous, active-high.
REQ-004 Start  in  1  request one line scan; sampled only in IDLE.
REQ-005 Data[3]  in  8 each  line-buffer read columns: [0]=top row, [1]=middle, [2]=bottom; holds column ReadAddr-of-previous-cycle (one-cycle registered read).
REQ-006 ReadAddr  out  8  column address driven to the line buffer.
REQ-007 Busy  out  1  scan in progress.
REQ-008 PixelValid  out  1  PixelOut/PixelAddr valid this cycle.
REQ-009 PixelOut  out  8  Sobel magnitude for middle row, column PixelAddr.
REQ-010 PixelAddr  out  8  column of PixelOut.
REQ-011 Done  out  1  one-cycle pulse after last pixel of the scan.

Function
REQ-012 FSM states IDLE, READ, DRAIN, DONE; IDLE->READ on Start; READ->DRAIN after ReadAddr=WIDTH-1 issued; DRAIN->DONE after last pixel emitted; DONE->IDLE unconditionally after one cycle.
REQ-013 Start sampled high at edge E0 -> READ from cycle 1; ReadAddr=x in cycle 1+x, x=0..WIDTH-1, +1 per cycle, no gaps.
REQ-014 ReadAddr holds 0 in IDLE, DONE and DRAIN.
REQ-015 Window: three 3x8-bit column registers L, C, R shift left each time a new column is captured from Data.
REQ-016 Edge replicate: column 0 uses L=C; column WIDTH-1 uses R=C.
REQ-017 Gx=(TR+2MR+BR)-(TL+2ML+BL), Gy=(BL+2BC+BR)-(TL+2TC+TR), signed 11-bit, no overflow.
REQ-018 PixelOut=min(|Gx|+|Gy|, 255); magnitude computed at 12 bits before saturation.
REQ-019 Result registered; PixelValid for column x asserted in cycle 5+x; exactly WIDTH consecutive valid cycles, PixelAddr 0..WIDTH-1 ascending.
REQ-020 Done high in cycle WIDTH+5 only; Busy high cycles 1..WIDTH+5 inclusive, low otherwise.
REQ-021 Start while Busy ignored; Start high in DONE cycle ignored; Start held high in IDLE begins a new scan each time IDLE is reached.
REQ-022 PixelOut and PixelAddr hold last values when PixelValid low.
REQ-023 WIDTH=2 supported: both columns use replicate on one side.

Reset
REQ-024 Reset high -> immediately: state IDLE, ReadAddr=0, Busy=0, PixelValid=0, PixelOut=0, PixelAddr=0, Done=0, window registers 0.
REQ-025 Reset mid-scan aborts scan; no Done pulse; next Start after Reset release restarts at column 0 with REQ-013 timing.

Verification
REQ-026 Constant image (all Data=77) -> WIDTH pixels, all PixelOut=0; Done at cycle 245 (WIDTH=240).
REQ-027 Vertical step (columns <120 =0, >=120 =255, all rows) -> PixelOut=255 at PixelAddr 119 and 120, 0 elsewhere.
REQ-028 Horizontal gradient (top=0, middle=10, bottom=20, all columns) -> PixelOut=80 at every column, including 0 and 239.
REQ-029 Ramp (every row = column index) -> PixelOut=4 at columns 0 and 239, 8 at columns 1..238.
REQ-030 Timing: Start pulse -> ReadAddr 0..239 in cycles 1..240, first PixelValid cycle 5, last cycle 244, Done cycle 245; second Start during Busy produces no extra scan.
REQ-031 Reset asserted at cycle 100 of a scan -> all outputs 0 asynchronously, no Done; subsequent Start -> full correct scan.

Source files
------------

// File: rtl/sobel_line_scanner.sv
// Streams one line of a 3-row line buffer through a 3x3 Sobel window and emits
// one saturated gradient magnitude per column of the middle row.
//
// state | meaning
// IDLE  | waiting for start, read address parked at 0
// READ  | issuing column addresses 0..WIDTH-1, one per cycle
// DRAIN | address parked, window pipeline finishing the last columns
// DONE  | one-cycle completion pulse, start ignored
module sobel_line_scanner #(
   parameter int WIDTH = 240
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data [3],
   output logic [7:0] read_addr,
   output logic       busy,
   output logic       pixel_valid,
   output logic [7:0] pixel_out,
   output logic [7:0] pixel_addr,
   output logic       done
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

   localparam logic [7:0] LAST_COL = 8'(WIDTH - 1);

   state_t state, state_nxt;
   logic   rd_active;

   logic       s1_v, s2_v, s3_v;
   logic [7:0] a1, a2, a3;
   logic [7:0] win_l [3];
   logic [7:0] win_c [3];
   logic [7:0] win_r [3];
   logic [7:0] lft [3];
   logic [7:0] rgt [3];

   logic [10:0]        sum_l, sum_r, sum_t, sum_b;
   logic signed [10:0] gx, gy;
   logic [10:0]        ax, ay;
   logic [11:0]        mag;
   logic [7:0]         mag_sat;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Drain ends on the registered last pixel, so DONE lands one cycle after it.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_READ;
         S_READ:  if (read_addr == LAST_COL) state_nxt = S_DRAIN;
         S_DRAIN: if (pixel_valid && pixel_addr == LAST_COL) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != S_IDLE);
      done      = (state == S_DONE);
      rd_active = (state == S_READ);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         read_addr <= 8'd0;
      else if (rd_active && read_addr != LAST_COL)
         read_addr <= read_addr + 8'd1;
      else
         read_addr <= 8'd0;
   end

   // s1: data on the bus, s3: window centred on that column (one column look-ahead).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v <= 1'b0;
         s2_v <= 1'b0;
         s3_v <= 1'b0;
         a1   <= 8'd0;
         a2   <= 8'd0;
         a3   <= 8'd0;
      end else begin
         s1_v <= rd_active;
         s2_v <= s1_v;
         s3_v <= s2_v;
         a1   <= read_addr;
         a2   <= a1;
         a3   <= a2;
      end
   end

   // The extra shift while only s2 is live moves the last column into C.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < 3; r++) begin
            win_l[r] <= 8'd0;
            win_c[r] <= 8'd0;
            win_r[r] <= 8'd0;
         end
      end else if (s1_v || s2_v) begin
         for (int r = 0; r < 3; r++) begin
            win_l[r] <= win_c[r];
            win_c[r] <= win_r[r];
            win_r[r] <= data[r];
         end
      end
   end

   always_comb begin
      for (int r = 0; r < 3; r++) begin
         lft[r] = (a3 == 8'd0)     ? win_c[r] : win_l[r];
         rgt[r] = (a3 == LAST_COL) ? win_c[r] : win_r[r];
      end
   end

   always_comb begin
      sum_l = {3'b000, lft[0]} + {2'b00, lft[1], 1'b0} + {3'b000, lft[2]};
      sum_r = {3'b000, rgt[0]} + {2'b00, rgt[1], 1'b0} + {3'b000, rgt[2]};
      sum_t = {3'b000, lft[0]} + {2'b00, win_c[0], 1'b0} + {3'b000, rgt[0]};
      sum_b = {3'b000, lft[2]} + {2'b00, win_c[2], 1'b0} + {3'b000, rgt[2]};
      gx    = $signed(sum_r - sum_l);
      gy    = $signed(sum_b - sum_t);
      ax    = gx[10] ? 11'(-gx) : 11'(gx);
      ay    = gy[10] ? 11'(-gy) : 11'(gy);
      mag   = {1'b0, ax} + {1'b0, ay};
      mag_sat = (mag > 12'd255) ? 8'hFF : mag[7:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pixel_valid <= 1'b0;
         pixel_out   <= 8'd0;
         pixel_addr  <= 8'd0;
      end else begin
         pixel_valid <= s3_v;
         if (s3_v) begin
            pixel_out  <= mag_sat;
            pixel_addr <= a3;
         end
      end
   end

endmodule

// File: tb/tb_sobel_line_scanner.sv
// Bench for sobel_line_scanner: models the registered line buffer, computes the
// Sobel magnitude per column from the image directly and checks cycle timing.
module tb_sobel_line_scanner;

   localparam int W = 240;

   logic       clk, rst, start;
   logic [7:0] data [3];
   logic [7:0] read_addr;
   logic       busy, pixel_valid, done;
   logic [7:0] pixel_out, pixel_addr;

   sobel_line_scanner #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .data(data),
      .read_addr(read_addr), .busy(busy), .pixel_valid(pixel_valid),
      .pixel_out(pixel_out), .pixel_addr(pixel_addr), .done(done)
   );

   int img [3][W];
   int got [W];
   int checks = 0;
   int failures = 0;
   int last_out = 0;
   int last_addr = 0;
   int addr_q = 0;

   typedef struct {
      int pat;
      int col;
      int exp;
   } vec_t;
   vec_t tbl [16];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Line buffer: data shows the column addressed in the previous cycle.
   initial forever begin
      @(negedge clk);
      addr_q = int'(read_addr);
   end
   initial forever begin
      @(posedge clk);
      #1;
      for (int r = 0; r < 3; r++) data[r] = 8'(img[r][addr_q % W]);
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int sobel_ref(input int x);
      int lx, rx, gx, gy, m;
      lx = (x == 0) ? 0 : x - 1;
      rx = (x == W - 1) ? W - 1 : x + 1;
      gx = (img[0][rx] + 2 * img[1][rx] + img[2][rx]) - (img[0][lx] + 2 * img[1][lx] + img[2][lx]);
      gy = (img[2][lx] + 2 * img[2][x] + img[2][rx]) - (img[0][lx] + 2 * img[0][x] + img[0][rx]);
      m  = iabs(gx) + iabs(gy);
      return (m > 255) ? 255 : m;
   endfunction

   task automatic load_pattern(input int pat, input int maxv);
      for (int x = 0; x < W; x++)
         for (int r = 0; r < 3; r++)
            case (pat)
               0: img[r][x] = 77;
               1: img[r][x] = (x < 120) ? 0 : 255;
               2: img[r][x] = 10 * r;
               3: img[r][x] = x;
               default: img[r][x] = $urandom_range(maxv, 0);
            endcase
   endtask

   // One full scan from a start pulse; cycle c is the cycle after edge E0+c-1.
   task automatic run_scan(input bit noisy);
      int er;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int c = 1; c <= W + 8; c++) begin
         @(negedge clk);
         er = (c >= 1 && c <= W) ? c - 1 : 0;
         chk("read_addr", int'(read_addr), er);
         chk("busy", int'(busy), int'(c <= W + 5));
         chk("done", int'(done), int'(c == W + 5));
         chk("pixel_valid", int'(pixel_valid), int'(c >= 5 && c <= W + 4));
         if (c >= 5 && c <= W + 4) begin
            chk("pixel_addr", int'(pixel_addr), c - 5);
            chk("pixel_out", int'(pixel_out), sobel_ref(c - 5));
            got[c - 5] = int'(pixel_out);
            last_out  = sobel_ref(c - 5);
            last_addr = c - 5;
         end else begin
            chk("hold_out", int'(pixel_out), last_out);
            chk("hold_addr", int'(pixel_addr), last_addr);
         end
         start = noisy && ((c >= 10 && c <= 12) || c == W + 5);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_read_addr"}, int'(read_addr), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_pixel_valid"}, int'(pixel_valid), 0);
      chk({tag, "_pixel_out"}, int'(pixel_out), 0);
      chk({tag, "_pixel_addr"}, int'(pixel_addr), 0);
      chk({tag, "_done"}, int'(done), 0);
   endtask

   initial begin
      bit seen;
      tbl[0]  = '{0, 0, 0};    tbl[1]  = '{0, 120, 0};  tbl[2]  = '{0, 239, 0};
      tbl[3]  = '{1, 0, 0};    tbl[4]  = '{1, 118, 0};  tbl[5]  = '{1, 119, 255};
      tbl[6]  = '{1, 120, 255}; tbl[7] = '{1, 121, 0};  tbl[8]  = '{1, 239, 0};
      tbl[9]  = '{2, 0, 80};   tbl[10] = '{2, 117, 80}; tbl[11] = '{2, 239, 80};
      tbl[12] = '{3, 0, 4};    tbl[13] = '{3, 1, 8};    tbl[14] = '{3, 238, 8};
      tbl[15] = '{3, 239, 4};

      rst = 1'b1; start = 1'b0;
      for (int r = 0; r < 3; r++) data[r] = 8'd0;
      load_pattern(0, 0);
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;

      for (int p = 0; p < 4; p++) begin
         load_pattern(p, 0);
         run_scan(1'b0);
         for (int i = 0; i < 16; i++)
            if (tbl[i].pat == p) chk($sformatf("pattern%0d_col%0d", p, tbl[i].col), got[tbl[i].col], tbl[i].exp);
      end

      load_pattern(9, 255); run_scan(1'b0);
      load_pattern(9, 30);  run_scan(1'b0);

      // Extra starts while busy and during DONE must not launch another scan.
      load_pattern(9, 60);  run_scan(1'b1);

      // Held start: a new scan begins the cycle after IDLE is re-entered.
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1;
      for (int c = 1; c <= W + 8; c++) begin
         @(negedge clk);
         if (c == W + 6) chk("held_idle_busy", int'(busy), 0);
         if (c == W + 7) begin
            chk("held_restart_busy", int'(busy), 1);
            chk("held_restart_addr", int'(read_addr), 0);
         end
         if (c == W + 8) begin
            chk("held_restart_addr1", int'(read_addr), 1);
            start = 1'b0;
         end
      end
      seen = 1'b0;
      for (int k = 0; k < W + 10 && !seen; k++) begin
         @(negedge clk);
         seen = done;
      end
      chk("held_second_done", int'(seen), 1);
      last_out = sobel_ref(W - 1);
      last_addr = W - 1;
      repeat (2) @(negedge clk);

      // Asynchronous reset in the middle of a scan.
      load_pattern(9, 255);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (100) @(negedge clk);
      rst = 1'b1;
      #1;
      chk_all_zero("async_reset");
      last_out = 0;
      last_addr = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < W + 10; k++) begin
         @(negedge clk);
         seen = seen | done | busy;
      end
      chk("abort_no_done", int'(seen), 0);
      run_scan(1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
